// File: rtl/univ_cnt_pkg.sv
// Shared definitions for the universal modulus counter.
//   MODE_*   : end-of-range behaviour selected by the mode input
//   ST_*     : one-shot state machine encoding
package univ_cnt_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  // 2'd3 is reserved and behaves as MODE_WRAP.

  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_DONE  = 1'b1
  } os_state_e;

endpackage

// File: rtl/cnt_step_unit.sv
// Combinational next-count calculator.
//   q        : current count
//   stp      : step magnitude (zero-extended internally)
//   limit    : terminal value, legal range is 0..limit
//   up       : 1 = count up, 0 = count down
//   mode     : end-of-range behaviour
//   next     : count after one enabled step
//   wrap     : the step wrapped around the range
//   boundary : one-shot reached its end of range
module cnt_step_unit
  import univ_cnt_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned S = 4
) (
  input  logic [N-1:0] q,
  input  logic [S-1:0] stp,
  input  logic [N-1:0] limit,
  input  logic         up,
  input  logic [1:0]   mode,
  output logic [N-1:0] next,
  output logic         wrap,
  output logic         boundary
);

  localparam int unsigned W = N + 1;

  logic [W-1:0] q_x;
  logic [W-1:0] stp_x;
  logic [W-1:0] lim_x;
  logic [W-1:0] l1;
  logic [W-1:0] sum;
  logic         is_sat;
  logic         is_oneshot;

  assign q_x        = {1'b0, q};
  assign stp_x      = W'(stp);
  assign lim_x      = {1'b0, limit};
  assign l1         = lim_x + {{N{1'b0}}, 1'b1};
  assign sum        = q_x + stp_x;
  assign is_sat     = (mode == MODE_SAT);
  assign is_oneshot = (mode == MODE_ONESHOT);

  always_comb begin
    next     = q;
    wrap     = 1'b0;
    boundary = 1'b0;
    if (q_x > lim_x) begin
      // Count left over from a load or a shrunk limit: pull back into range.
      if (up && !is_sat && !is_oneshot) begin
        next = '0;
        wrap = 1'b1;
      end else begin
        next = limit;
      end
    end else if (up) begin
      if (sum <= lim_x) begin
        next = N'(sum);
      end else if (is_sat) begin
        next = limit;
      end else if (is_oneshot) begin
        next     = limit;
        boundary = 1'b1;
      end else begin
        // Single subtract; only exact when stp <= limit + 1.
        next = N'(sum - l1);
        wrap = 1'b1;
      end
    end else begin
      if (q_x >= stp_x) begin
        next = N'(q_x - stp_x);
      end else if (is_sat) begin
        next = '0;
      end else if (is_oneshot) begin
        next     = '0;
        boundary = 1'b1;
      end else begin
        next = N'(q_x + l1 - stp_x);
        wrap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/univ_mod_counter.sv
// Up/down counter with runtime modulus, variable step and wrap/saturate/one-shot end modes.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   syn_clr, load : synchronous clear / load of d (both re-arm the one-shot)
//   en, up, step  : count enable, direction, increment (0 holds)
//   limit, mode   : terminal value and end-of-range behaviour
//   cmp           : compare value for match_tick
//   q             : registered count
//   max_tick      : q == limit (combinational)
//   min_tick      : q == 0 (combinational)
//   wrap_tick     : registered pulse aligned with a wrapped q
//   match_tick    : registered pulse aligned with q newly equal to cmp
//   done          : one-shot finished
module univ_mod_counter
  import univ_cnt_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         syn_clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         en,
  input  logic         up,
  input  logic [S-1:0] step,
  input  logic [N-1:0] limit,
  input  logic [1:0]   mode,
  input  logic [N-1:0] cmp,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap_tick,
  output logic         match_tick,
  output logic         done
);

  os_state_e    state_q, state_d;
  logic [N-1:0] q_d;
  logic         wrap_d;
  logic         match_d;
  logic         go;
  logic [N-1:0] nxt;
  logic         nxt_wrap;
  logic         nxt_boundary;

  cnt_step_unit #(
    .N (N),
    .S (S)
  ) u_step (
    .q        (q),
    .stp      (step),
    .limit    (limit),
    .up       (up),
    .mode     (mode),
    .next     (nxt),
    .wrap     (nxt_wrap),
    .boundary (nxt_boundary)
  );

  assign go = en && (step != '0) && (state_q == ST_ARMED);

  always_comb begin
    q_d     = q;
    state_d = state_q;
    wrap_d  = 1'b0;
    match_d = 1'b0;
    if (syn_clr) begin
      q_d     = '0;
      state_d = ST_ARMED;
      match_d = (cmp == '0);
    end else if (load) begin
      q_d     = d;
      state_d = ST_ARMED;
      match_d = (d == cmp);
    end else begin
      // Leaving one-shot mode releases a finished counter.
      if ((state_q == ST_DONE) && (mode != MODE_ONESHOT)) begin
        state_d = ST_ARMED;
      end
      if (go) begin
        q_d     = nxt;
        wrap_d  = nxt_wrap;
        // A count that lands on its own value is not a new match.
        match_d = (nxt == cmp) && (nxt != q);
        if (nxt_boundary) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= '0;
      state_q    <= ST_ARMED;
      wrap_tick  <= 1'b0;
      match_tick <= 1'b0;
    end else begin
      q          <= q_d;
      state_q    <= state_d;
      wrap_tick  <= wrap_d;
      match_tick <= match_d;
    end
  end

  assign done     = (state_q == ST_DONE);
  assign max_tick = (q == limit);
  assign min_tick = (q == '0);

endmodule

// File: tb/tb_univ_mod_counter.sv
module tb_univ_mod_counter;

  localparam int unsigned N = 8;
  localparam int unsigned S = 4;

  logic         clk;
  logic         rst;
  logic         syn_clr;
  logic         load;
  logic [N-1:0] d;
  logic         en;
  logic         up;
  logic [S-1:0] step;
  logic [N-1:0] limit;
  logic [1:0]   mode;
  logic [N-1:0] cmp;
  logic [N-1:0] q;
  logic         max_tick;
  logic         min_tick;
  logic         wrap_tick;
  logic         match_tick;
  logic         done;

  int checks;
  int errors;

  univ_mod_counter #(
    .N (N),
    .S (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .syn_clr    (syn_clr),
    .load       (load),
    .d          (d),
    .en         (en),
    .up         (up),
    .step       (step),
    .limit      (limit),
    .mode       (mode),
    .cmp        (cmp),
    .q          (q),
    .max_tick   (max_tick),
    .min_tick   (min_tick),
    .wrap_tick  (wrap_tick),
    .match_tick (match_tick),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q !== 8'd0 || wrap_tick !== 1'b0 || match_tick !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%0d wrap=%b match=%b done=%b, want 0 0 0 0",
               q, wrap_tick, match_tick, done);
    end
    checks++;
    if (max_tick !== 1'b1 || min_tick !== 1'b1) begin
      errors++;
      $display("FAIL reset_ticks_lim0: max=%b min=%b, want 1 1", max_tick, min_tick);
    end
    limit = 8'd9;
    #1;
    checks++;
    if (max_tick !== 1'b0 || min_tick !== 1'b1) begin
      errors++;
      $display("FAIL reset_ticks_lim9: max=%b min=%b, want 0 1", max_tick, min_tick);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_wrap();
    logic [7:0] exp_q [5];
    exp_q[0] = 8'd3; exp_q[1] = 8'd6; exp_q[2] = 8'd9; exp_q[3] = 8'd2; exp_q[4] = 8'd5;
    limit = 8'd9; step = 4'd3; mode = 2'd0; up = 1'b1; cmp = 8'd200;
    syn_clr = 1'b1; en = 1'b0;
    tick();
    syn_clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || wrap_tick !== (i == 3)) begin
        errors++;
        $display("FAIL basic_wrap[%0d]: q=%0d wrap=%b, want q=%0d wrap=%b",
                 i, q, wrap_tick, exp_q[i], (i == 3));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    limit = 8'd9; step = 4'd4; up = 1'b0; mode = 2'd0; cmp = 8'd200;
    load = 1'b1; d = 8'd1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (q !== 8'd7 || wrap_tick !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: q=%0d wrap=%b, want q=7 wrap=1", q, wrap_tick);
    end
    mode = 2'd1; load = 1'b1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== 8'd0 || wrap_tick !== 1'b0) begin
        errors++;
        $display("FAIL down_sat[%0d]: q=%0d wrap=%b, want q=0 wrap=0", i, q, wrap_tick);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_q [5];
    exp_q[0] = 8'd2; exp_q[1] = 8'd4; exp_q[2] = 8'd5; exp_q[3] = 8'd5; exp_q[4] = 8'd5;
    limit = 8'd5; step = 4'd2; mode = 2'd2; up = 1'b1; cmp = 8'd200;
    syn_clr = 1'b1; en = 1'b0;
    tick();
    syn_clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || done !== (i >= 2) || wrap_tick !== 1'b0) begin
        errors++;
        $display("FAIL oneshot[%0d]: q=%0d done=%b wrap=%b, want q=%0d done=%b wrap=0",
                 i, q, done, wrap_tick, exp_q[i], (i >= 2));
      end
    end
    load = 1'b1; d = 8'd1;
    tick();
    load = 1'b0; en = 1'b0;
    checks++;
    if (q !== 8'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_reload: q=%0d done=%b, want q=1 done=0", q, done);
    end
  endtask

  task automatic test_out_of_range();
    limit = 8'd100; mode = 2'd0; up = 1'b1; step = 4'd1; cmp = 8'd250;
    load = 1'b1; d = 8'd200; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (q !== 8'd0 || wrap_tick !== 1'b1) begin
      errors++;
      $display("FAIL out_of_range: q=%0d wrap=%b, want q=0 wrap=1", q, wrap_tick);
    end
    load = 1'b1; d = 8'd55;
    tick();
    syn_clr = 1'b1;
    tick();
    syn_clr = 1'b0; load = 1'b0; en = 1'b0;
    checks++;
    if (q !== 8'd0) begin
      errors++;
      $display("FAIL clr_over_load: q=%0d, want 0", q);
    end
  endtask

  task automatic test_compare();
    logic [7:0] exp_q [4];
    logic       exp_m [4];
    exp_q[0] = 8'd3; exp_q[1] = 8'd6; exp_q[2] = 8'd6; exp_q[3] = 8'd6;
    exp_m[0] = 1'b0; exp_m[1] = 1'b1; exp_m[2] = 1'b0; exp_m[3] = 1'b0;
    limit = 8'd9; step = 4'd3; up = 1'b1; mode = 2'd0; cmp = 8'd6;
    syn_clr = 1'b1; en = 1'b0;
    tick();
    syn_clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      en = 1'b0;
      checks++;
      if (q !== exp_q[i] || match_tick !== exp_m[i]) begin
        errors++;
        $display("FAIL compare[%0d]: q=%0d match=%b, want q=%0d match=%b",
                 i, q, match_tick, exp_q[i], exp_m[i]);
      end
      if (i == 0) en = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    limit = 8'd7; step = 4'd4; up = 1'b1; mode = 2'd2; cmp = 8'd200;
    syn_clr = 1'b1; en = 1'b0;
    tick();
    syn_clr = 1'b0; en = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== 8'd7 || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: q=%0d done=%b, want q=7 done=1", q, done);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'd0 || done !== 1'b0 || wrap_tick !== 1'b0 || match_tick !== 1'b0
        || min_tick !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: q=%0d done=%b wrap=%b match=%b min=%b, want 0 0 0 0 1",
               q, done, wrap_tick, match_tick, min_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (q !== 8'd4 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume: q=%0d done=%b, want q=4 done=0", q, done);
    end
    en = 1'b0;
  endtask

  // Random traffic against a plain-arithmetic model of the counting rules.
  task automatic test_random();
    int m_q;
    int m_done;
    int nq, ndone, nwrap, nmatch;
    int lq, sv;
    m_q = 0;
    m_done = 0;
    for (int i = 0; i < 400; i++) begin
      syn_clr = (i == 0) || ($urandom_range(0, 31) == 0);
      load    = ($urandom_range(0, 7) == 0);
      d       = 8'($urandom_range(0, 255));
      en      = ($urandom_range(0, 3) != 0);
      up      = 1'($urandom_range(0, 1));
      if (i == 0 || $urandom_range(0, 7) == 0)
        limit = 8'($urandom_range(0, 1) != 0 ? $urandom_range(0, 20) : $urandom_range(0, 255));
      if (i == 0 || $urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      cmp = ($urandom_range(0, 1) != 0) ? limit : 8'($urandom_range(0, 20));
      lq = int'(limit);
      sv = $urandom_range(0, 15);
      if (sv > lq + 1) sv = sv % (lq + 2);
      step = 4'(sv);

      nq = m_q; ndone = m_done; nwrap = 0; nmatch = 0;
      if (syn_clr) begin
        nq = 0; ndone = 0; nmatch = (int'(cmp) == 0);
      end else if (load) begin
        nq = int'(d); ndone = 0; nmatch = (int'(d) == int'(cmp));
      end else begin
        if (m_done != 0 && mode != 2'd2) ndone = 0;
        if (en && sv != 0 && m_done == 0) begin
          if (m_q > lq) begin
            if (up && (mode == 2'd0 || mode == 2'd3)) begin
              nq = 0; nwrap = 1;
            end else begin
              nq = lq;
            end
          end else if (up) begin
            if (m_q + sv <= lq) nq = m_q + sv;
            else if (mode == 2'd1) nq = lq;
            else if (mode == 2'd2) begin nq = lq; ndone = 1; end
            else begin nq = (m_q + sv) % (lq + 1); nwrap = 1; end
          end else begin
            if (m_q >= sv) nq = m_q - sv;
            else if (mode == 2'd1) nq = 0;
            else if (mode == 2'd2) begin nq = 0; ndone = 1; end
            else begin nq = m_q - sv + lq + 1; nwrap = 1; end
          end
          nmatch = (nq == int'(cmp)) && (nq != m_q);
        end
      end
      m_q = nq;
      m_done = ndone;

      tick();
      checks++;
      if (int'(q) != m_q || int'(done) != m_done) begin
        errors++;
        $display("FAIL random[%0d] q/done: q=%0d done=%b, want q=%0d done=%0d",
                 i, q, done, m_q, m_done);
        m_q = int'(q);
        m_done = int'(done);
      end
      checks++;
      if (int'(wrap_tick) != nwrap || int'(match_tick) != nmatch) begin
        errors++;
        $display("FAIL random[%0d] ticks: wrap=%b match=%b, want wrap=%0d match=%0d",
                 i, wrap_tick, match_tick, nwrap, nmatch);
      end
      checks++;
      if (max_tick !== (m_q == lq) || min_tick !== (m_q == 0)) begin
        errors++;
        $display("FAIL random[%0d] max/min: max=%b min=%b, want max=%b min=%b",
                 i, max_tick, min_tick, (m_q == lq), (m_q == 0));
      end
    end
    syn_clr = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    syn_clr = 1'b0; load = 1'b0; d = '0; en = 1'b0; up = 1'b1;
    step = '0; limit = '0; mode = 2'd0; cmp = '0;
    test_reset();
    test_basic_wrap();
    test_down_wrap();
    test_oneshot();
    test_out_of_range();
    test_compare();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_mod_counter.md
# univ_mod_counter

Parametrised up/down counter with a runtime modulus, variable step and three end-of-range modes: wrap, saturate and one-shot. It generalises the plain binary counter for timer, prescaler and address-generator uses, where the terminal count, increment and end behaviour are set per use. It also provides a compare-match pulse and a wrap pulse for cascading counters.

## Interface
- N, 8, counter width (2..32)
- S, 4, step input width (1..N)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- syn_clr  in  1  synchronous clear to 0, re-arms one-shot
- load  in  1  synchronous load of d, re-arms one-shot
- d  in  N  load value
- en  in  1  count enable
- up  in  1  1 = count up, 0 = count down
- step  in  S  increment magnitude; 0 means hold
- limit  in  N  terminal value; legal range is 0..limit
- mode  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (treated as WRAP)
- cmp  in  N  compare value
- q  out  N  count, registered
- max_tick  out  1  combinational, (q == limit)
- min_tick  out  1  combinational, (q == 0)
- wrap_tick  out  1  registered pulse, high the cycle after a wrap
- match_tick  out  1  registered pulse, high the cycle after q becomes cmp
- done  out  1  registered, one-shot finished

## Operation
- Priority: rst > syn_clr > load > (en & step != 0 & ~done) > hold.
- All arithmetic is done at N+1 bits. L1 = limit + 1 (N+1 bits). stp = zero-extended step.
- Up, q ≤ limit, sum = q + stp:
  - sum ≤ limit: next = sum.
  - sum > limit, WRAP: next = sum − L1 (single subtract); assert wrap.
  - sum > limit, SAT: next = limit.
  - sum > limit, ONESHOT: next = limit; set done.
- Down, q ≤ limit:
  - q ≥ stp: next = q − stp.
  - q < stp, WRAP: next = q + L1 − stp; assert wrap.
  - q < stp, SAT: next = 0.
  - q < stp, ONESHOT: next = 0; set done.
- step > L1 is illegal. Under WRAP the result is defined as the single-subtract value, truncated to N bits. The bench does not check it.
- Out of range (q > limit, after a load or a change of limit) with an enabled count:
  - up & WRAP: next = 0 with wrap.
  - Every other case: next = limit.
- One-shot state machine:
  - States: ARMED and DONE. done = (state == DONE).
  - ARMED → DONE when the boundary condition above occurs.
  - DONE → ARMED on syn_clr, on load, or when mode is written to a value other than ONESHOT.
  - In DONE, en is ignored and q holds.
- match_tick fires when the next value equals cmp and either differs from q or came from a load or clear. A constant q does not re-fire.
- mode and limit may change on any cycle and take effect in the same cycle's next-state computation.

## Timing
- Reset values: q = 0, wrap_tick = 0, match_tick = 0, done = 0, state ARMED. While rst is asserted and q = 0, max_tick = (limit == 0) and min_tick = 1.
- q updates on the clk edge after its inputs settle; latency is 1 cycle.
- wrap_tick and match_tick are registered in the same edge as the q update that causes them. Each is a one-cycle pulse aligned with the new q.
- done rises in the same edge that q reaches the boundary.
- Reset asserted mid-count clears everything immediately. Deassertion is expected synchronously to clk.
- syn_clr and load in the same cycle: syn_clr wins and q = 0.

## Structure
- Package univ_cnt_pkg holds:
  - mode constants MODE_WRAP, MODE_SAT, MODE_ONESHOT.
  - state encodings ST_ARMED, ST_DONE.
- Sub-module cnt_step_unit (combinational) computes next value, wrap flag and boundary flag from q, stp, limit, up and mode.
- The top level holds the register, the one-shot state machine, the tick registers and the output compares.

## Test plan
- Basic wrap: N=8, limit=9, step=3, WRAP, up from 0 → q sequence 3, 6, 9, 2, 5. wrap_tick is high with q=2.
- Down wrap: limit=9, step=4, down from 1 → q=7 with wrap_tick. Repeat in SAT mode → q=0 and holds there, no wrap_tick.
- One-shot: limit=5, step=2, ONESHOT, up → q sequence 2, 4, 5. done rises with q=5; en held high leaves q=5. A following load d=1 → q=1, done=0.
- Out of range and priority:
  - load d=200 with limit=100, then en up WRAP → q=0 with wrap_tick.
  - syn_clr and load together → q=0.
- Compare: cmp=6, limit=9, step=3, up → match_tick once when q becomes 6. It does not fire while q holds at 6 with en=0.
- Reset mid-run: assert rst while q=7 and done=1 → q=0, done=0, all ticks 0 in the same cycle. Counting resumes normally after release.
